rename_unit: RTL and testbench

Register-rename stage sitting directly upstream of the reservation station. Each cycle it accepts at most one decoded instruction, maps its architectural sources and destination onto the 32-entry physical register file, and allocates a fresh physical destination from a free list. It tracks per-physical-register readiness from CDB broadcasts, so the RS receives correct `prs*_valid` bits at allocation. It also returns physical registers released at commit to the free list.

---
 rtl/rename_unit.sv | 188 ++++++++++++++++++
 tb/tb_rename_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// Register rename: map table, free list and ready table feeding the RS.
// Optional RENAME_STALL_CNT_EN builds the input stall counter.
module rename_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [3:0]  rs1_i,
  input  logic [3:0]  rs2_i,
  input  logic [3:0]  rd_i,
  input  logic        rd_we_i,
  output logic        out_valid_o,
  input  logic        rs_free_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [4:0]  prs1_addr_o,
  output logic [4:0]  prs2_addr_o,
  output logic [4:0]  prd_addr_o,
  output logic        prs1_valid_o,
  output logic        prs2_valid_o,
  output logic [4:0]  old_prd_o,
  input  logic        cdb_en_i,
  input  logic [4:0]  cdb_tag_i,
  input  logic        commit_free_en_i,
  input  logic [4:0]  commit_free_tag_i,
  output logic        fl_overflow_o,
  output logic [31:0] stall_cnt_o
);

  logic [4:0]  map_q [16];
  logic [4:0]  map_d [16];
  logic [31:0] ready_q, ready_d;
  logic [4:0]  fl_q [16];
  logic [4:0]  fl_d [16];
  logic [3:0]  head_q, head_d;
  logic [3:0]  tail_q, tail_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic        vld_q, vld_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [4:0]  prs1_q, prs1_d;
  logic [4:0]  prs2_q, prs2_d;
  logic [4:0]  prd_q, prd_d;
  logic [4:0]  old_q, old_d;
  logic        v1_q, v1_d;
  logic        v2_q, v2_d;

  logic       accept, alloc, push, hold, xfer, cdb_hit;
  logic [4:0] src1, src2, new_prd;

  assign in_ready_o = (!vld_q || rs_free_i) && (cnt_q != 5'd0);
  assign accept     = in_valid_i && in_ready_o;
  assign alloc      = accept && rd_we_i && (rd_i != 4'd0);
  assign hold       = vld_q && !rs_free_i;
  assign xfer       = vld_q && rs_free_i;
  assign cdb_hit    = cdb_en_i && (cdb_tag_i != 5'd0);
  assign push       = commit_free_en_i && (commit_free_tag_i != 5'd0)
                      && (cnt_q != 5'd16);
  assign src1       = map_q[rs1_i];
  assign src2       = map_q[rs2_i];
  assign new_prd    = fl_q[head_q];

  always_comb begin
    map_d   = map_q;
    ready_d = ready_q;
    fl_d    = fl_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q + 5'(push) - 5'(alloc);
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    prs1_d  = prs1_q;
    prs2_d  = prs2_q;
    prd_d   = prd_q;
    old_d   = old_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    if (cdb_hit)
      ready_d[cdb_tag_i] = 1'b1;
    // allocation clear is applied after the CDB set so it wins
    if (alloc) begin
      map_d[rd_i]      = new_prd;
      ready_d[new_prd] = 1'b0;
      head_d           = head_q + 4'd1;
    end
    if (push) begin
      fl_d[tail_q] = commit_free_tag_i;
      tail_d       = tail_q + 4'd1;
    end
    if (commit_free_en_i && (commit_free_tag_i != 5'd0)
        && (cnt_q == 5'd16))
      ovf_d = 1'b1;
    if (hold && cdb_hit) begin
      if (cdb_tag_i == prs1_q) v1_d = 1'b1;
      if (cdb_tag_i == prs2_q) v2_d = 1'b1;
    end
    if (accept) begin
      vld_d  = 1'b1;
      pc_d   = pc_i;
      inst_d = inst_i;
      prs1_d = src1;
      prs2_d = src2;
      v1_d   = ready_q[src1] || (src1 == 5'd0)
               || (cdb_en_i && cdb_tag_i == src1);
      v2_d   = ready_q[src2] || (src2 == 5'd0)
               || (cdb_en_i && cdb_tag_i == src2);
      prd_d  = alloc ? new_prd : 5'd0;
      old_d  = alloc ? map_q[rd_i] : 5'd0;
    end else if (xfer) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 16; i++) begin
        map_q[i] <= 5'(i);
        fl_q[i]  <= 5'(16 + i);
      end
      ready_q <= '1;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 5'd16;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      prs1_q  <= '0;
      prs2_q  <= '0;
      prd_q   <= '0;
      old_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      map_q   <= map_d;
      fl_q    <= fl_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      prs1_q  <= prs1_d;
      prs2_q  <= prs2_d;
      prd_q   <= prd_d;
      old_q   <= old_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

  assign out_valid_o   = vld_q;
  assign pc_o          = pc_q;
  assign inst_o        = inst_q;
  assign prs1_addr_o   = prs1_q;
  assign prs2_addr_o   = prs2_q;
  assign prd_addr_o    = prd_q;
  assign old_prd_o     = old_q;
  assign prs1_valid_o  = v1_q;
  assign prs2_valid_o  = v2_q;
  assign fl_overflow_o = ovf_q;

`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  assign stall_d = stall_q + 32'd1;

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      stall_q <= '0;
    else if (in_valid_i && !in_ready_o)
      stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rename_unit.sv
// Directed self-checking bench for rename_unit.
// Walks reset, renaming, bypass, free-list exhaustion, stall and reset.
module tb_rename_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i, inst_i;
  logic [3:0]  rs1_i, rs2_i, rd_i;
  logic        rd_we_i;
  logic        out_valid_o;
  logic        rs_free_i;
  logic [31:0] pc_o, inst_o;
  logic [4:0]  prs1_addr_o, prs2_addr_o, prd_addr_o, old_prd_o;
  logic        prs1_valid_o, prs2_valid_o;
  logic        cdb_en_i;
  logic [4:0]  cdb_tag_i;
  logic        commit_free_en_i;
  logic [4:0]  commit_free_tag_i;
  logic        fl_overflow_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_stall;

  rename_unit dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .rd_we_i(rd_we_i), .out_valid_o(out_valid_o),
    .rs_free_i(rs_free_i), .pc_o(pc_o), .inst_o(inst_o),
    .prs1_addr_o(prs1_addr_o), .prs2_addr_o(prs2_addr_o),
    .prd_addr_o(prd_addr_o),
    .prs1_valid_o(prs1_valid_o), .prs2_valid_o(prs2_valid_o),
    .old_prd_o(old_prd_o),
    .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i),
    .commit_free_en_i(commit_free_en_i),
    .commit_free_tag_i(commit_free_tag_i),
    .fl_overflow_o(fl_overflow_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic ren(input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] d, input logic we);
    in_valid_i = 1'b1;
    rs1_i      = a;
    rs2_i      = b;
    rd_i       = d;
    rd_we_i    = we;
  endtask

  initial begin
    reset_i = 1'b0; in_valid_i = 1'b0; pc_i = '0; inst_i = '0;
    rs1_i = '0; rs2_i = '0; rd_i = '0; rd_we_i = 1'b0;
    rs_free_i = 1'b1; cdb_en_i = 1'b0; cdb_tag_i = '0;
    commit_free_en_i = 1'b0; commit_free_tag_i = '0;
`ifdef RENAME_STALL_CNT_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    step(); step();
    reset_i = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_prd", 32'(prd_addr_o), 32'd0);
    chk("rst_ovf", 32'(fl_overflow_o), 32'd0);
    chk("rst_ready", 32'(in_ready_o), 32'd1);

    pc_i = 32'h100; inst_i = 32'hABCD;
    ren(4'd3, 4'd4, 4'd5, 1'b1);
    step();
    chk("r1_valid", 32'(out_valid_o), 32'd1);
    chk("r1_prs1", 32'(prs1_addr_o), 32'd3);
    chk("r1_prs2", 32'(prs2_addr_o), 32'd4);
    chk("r1_v1", 32'(prs1_valid_o), 32'd1);
    chk("r1_v2", 32'(prs2_valid_o), 32'd1);
    chk("r1_prd", 32'(prd_addr_o), 32'd16);
    chk("r1_old", 32'(old_prd_o), 32'd5);
    chk("r1_pc", pc_o, 32'h100);
    chk("r1_inst", inst_o, 32'hABCD);

    ren(4'd5, 4'd0, 4'd6, 1'b1);
    step();
    chk("r2_prs1", 32'(prs1_addr_o), 32'd16);
    chk("r2_v1", 32'(prs1_valid_o), 32'd0);
    chk("r2_prd", 32'(prd_addr_o), 32'd17);
    chk("r2_old", 32'(old_prd_o), 32'd6);

    in_valid_i = 1'b0; rs_free_i = 1'b0;
    cdb_en_i = 1'b1; cdb_tag_i = 5'd16;
    step();
    chk("hold_v1_rise", 32'(prs1_valid_o), 32'd1);
    chk("hold_prd", 32'(prd_addr_o), 32'd17);
    chk("hold_valid", 32'(out_valid_o), 32'd1);

    rs_free_i = 1'b1; cdb_tag_i = 5'd17;
    ren(4'd6, 4'd5, 4'd7, 1'b1);
    step();
    chk("byp_prs1", 32'(prs1_addr_o), 32'd17);
    chk("byp_v1", 32'(prs1_valid_o), 32'd1);
    chk("byp_v2", 32'(prs2_valid_o), 32'd1);
    chk("byp_prd", 32'(prd_addr_o), 32'd18);

    cdb_tag_i = 5'd19;
    ren(4'd0, 4'd0, 4'd8, 1'b1);
    step();
    chk("clr_prd", 32'(prd_addr_o), 32'd19);
    cdb_en_i = 1'b0;
    ren(4'd8, 4'd0, 4'd0, 1'b0);
    step();
    chk("clr_prs1", 32'(prs1_addr_o), 32'd19);
    chk("clr_v1", 32'(prs1_valid_o), 32'd0);
    chk("nowe_prd", 32'(prd_addr_o), 32'd0);

    for (int i = 0; i < 12; i++) begin
      ren(4'd1, 4'd2, 4'd9, 1'b1);
      step();
      chk("drain_prd", 32'(prd_addr_o), 32'(20 + i));
    end
    in_valid_i = 1'b0;
    #1;
    chk("empty_ready", 32'(in_ready_o), 32'd0);

    commit_free_en_i = 1'b1; commit_free_tag_i = 5'd5;
    step();
    commit_free_en_i = 1'b0;
    #1;
    chk("commit_ready", 32'(in_ready_o), 32'd1);
    ren(4'd0, 4'd0, 4'd10, 1'b1);
    step();
    chk("reuse_prd", 32'(prd_addr_o), 32'd5);
    chk("reuse_old", 32'(old_prd_o), 32'd10);

    in_valid_i = 1'b0;
    commit_free_en_i = 1'b1; commit_free_tag_i = 5'd20;
    step();
    commit_free_en_i = 1'b0;
    ren(4'd10, 4'd0, 4'd0, 1'b1);
    step();
    chk("x0_prs1", 32'(prs1_addr_o), 32'd5);
    chk("x0_prd", 32'(prd_addr_o), 32'd0);
    chk("x0_old", 32'(old_prd_o), 32'd0);
    chk("x0_nopop", 32'(in_ready_o), 32'd1);
    ren(4'd0, 4'd0, 4'd11, 1'b1);
    step();
    chk("after_x0_prd", 32'(prd_addr_o), 32'd20);
    chk("after_x0_old", 32'(old_prd_o), 32'd11);

    rs_free_i = 1'b0;
    pc_i = 32'h200;
    ren(4'd1, 4'd1, 4'd12, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", 32'(in_ready_o), 32'd0);
      chk("stall_prd", 32'(prd_addr_o), 32'd20);
      chk("stall_valid", 32'(out_valid_o), 32'd1);
    end
    chk("stall_cnt", stall_cnt_o, exp_stall);

    in_valid_i = 1'b0;
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
    rs_free_i = 1'b1;
    #1;
    chk("rst2_valid", 32'(out_valid_o), 32'd0);
    chk("rst2_prd", 32'(prd_addr_o), 32'd0);
    chk("rst2_old", 32'(old_prd_o), 32'd0);
    chk("rst2_pc", pc_o, 32'd0);
    chk("rst2_stall", stall_cnt_o, 32'd0);
    chk("rst2_ovf", 32'(fl_overflow_o), 32'd0);

    commit_free_en_i = 1'b1; commit_free_tag_i = 5'd7;
    step();
    commit_free_en_i = 1'b0;
    chk("ovf_set", 32'(fl_overflow_o), 32'd1);
    ren(4'd5, 4'd9, 4'd5, 1'b1);
    step();
    chk("post_rst_prd", 32'(prd_addr_o), 32'd16);
    chk("post_rst_old", 32'(old_prd_o), 32'd5);
    chk("post_rst_prs1", 32'(prs1_addr_o), 32'd5);
    chk("post_rst_v1", 32'(prs1_valid_o), 32'd1);
    chk("ovf_sticky", 32'(fl_overflow_o), 32'd1);
    in_valid_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
